// File: rtl/sram_1r1w_bwe_pkg.sv
// +------------------------------------------------------------------+
// | sram_1r1w_bwe_pkg : shared state encoding and legacy line types   |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

package sram_1r1w_bwe_pkg;

  typedef logic [0:0] state_t;
  localparam state_t CLEAR = 1'b0;
  localparam state_t RUN   = 1'b1;

  // Line types kept so older cache wrappers still compile unchanged.
  typedef logic [511:0] ICacheLine;
  typedef logic [511:0] DCacheLine;

endpackage

`default_nettype wire

// File: rtl/sram_1r1w_core.sv
// +------------------------------------------------------------------+
// | sram_1r1w_core : byte-enabled 1R1W array with registered read     |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module sram_1r1w_core #(
  parameter int WID  = 512,
  parameter int DEP  = 512,
  parameter int AWID = $clog2(DEP)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WID/8-1:0]  wsel,
  input  logic [AWID-1:0]   waddr,
  input  logic [WID-1:0]    wdata,
  input  logic              re,
  input  logic [AWID-1:0]   raddr,
  output logic [WID-1:0]    rdata
);

  logic [WID-1:0] mem [DEP];

  // Read returns pre-write contents on a collision; the top handles forwarding.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < WID/8; b++) begin
        if (wsel[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
    if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/sram_1r1w_bwe.sv
// +------------------------------------------------------------------+
// | sram_1r1w_bwe : 1R1W SRAM, byte enables, write-first forwarding,  |
// | LAT 1/2 read pipeline, optional zero-fill after reset. rev 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

module sram_1r1w_bwe
  import sram_1r1w_bwe_pkg::*;
#(
  parameter int WID        = 512,
  parameter int DEP        = 512,
  parameter int AWID       = $clog2(DEP),
  parameter int LAT        = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [WID/8-1:0]  wsel,
  input  logic [AWID-1:0]   wadr,
  input  logic [WID-1:0]    i,
  input  logic              rd,
  input  logic [AWID-1:0]   radr,
  output logic [WID-1:0]    o,
  output logic              ov,
  output logic              busy
);

  localparam int          NB        = WID / 8;
  localparam logic [AWID-1:0] LAST  = AWID'(DEP - 1);
  localparam logic [AWID:0]   DEP_W = (AWID + 1)'(DEP);
  localparam state_t      RST_STATE = (CLR_ON_RST != 0) ? CLEAR : RUN;

  state_t          state_q, state_d;
  logic [AWID-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + AWID'(1);
      if (cnt_q == LAST) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RST_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic clearing, run, wr_ok, rd_ok, rd_oob;
  assign clearing = (state_q == CLEAR);
  assign run      = (state_q == RUN) & ~rst;
  assign wr_ok    = run & wr & ({1'b0, wadr} < DEP_W);
  assign rd_ok    = run & rd;
  assign rd_oob   = ~({1'b0, radr} < DEP_W);
  assign busy     = clearing;

  logic [WID-1:0] core_rdata;

  sram_1r1w_core #(
    .WID  (WID),
    .DEP  (DEP),
    .AWID (AWID)
  ) u_core (
    .clk   (clk),
    .we    (clearing | wr_ok),
    .wsel  (clearing ? {NB{1'b1}} : wsel),
    .waddr (clearing ? cnt_q : wadr),
    .wdata (clearing ? {WID{1'b0}} : i),
    .re    (rd_ok & ~rd_oob),
    .raddr (radr),
    .rdata (core_rdata)
  );

  // Forwarding context is captured only on a read so the merge holds between reads.
  // zero_q resets high so o reads 0 before the first read refreshes the array register.
  logic           v1_q, v1_d;
  logic           zero_q, zero_d;
  logic           fwd_q, fwd_d;
  logic [NB-1:0]  fsel_q, fsel_d;
  logic [WID-1:0] fdat_q, fdat_d;

  always_comb begin
    v1_d   = rd_ok;
    zero_d = zero_q;
    fwd_d  = fwd_q;
    fsel_d = fsel_q;
    fdat_d = fdat_q;
    if (rd_ok) begin
      zero_d = rd_oob;
      fwd_d  = wr_ok & (wadr == radr);
      fsel_d = wsel;
      fdat_d = i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      zero_q <= 1'b1;
      fwd_q  <= 1'b0;
      fsel_q <= '0;
      fdat_q <= '0;
    end else begin
      v1_q   <= v1_d;
      zero_q <= zero_d;
      fwd_q  <= fwd_d;
      fsel_q <= fsel_d;
      fdat_q <= fdat_d;
    end
  end

  logic [WID-1:0] merged;

  always_comb begin
    merged = core_rdata;
    for (int b = 0; b < NB; b++) begin
      if (fwd_q && fsel_q[b]) merged[b*8 +: 8] = fdat_q[b*8 +: 8];
    end
    if (zero_q) merged = '0;
  end

  generate
    if (LAT == 2) begin : g_lat2
      logic [WID-1:0] o2_q, o2_d;
      logic           v2_q, v2_d;

      always_comb begin
        o2_d = v1_q ? merged : o2_q;
        v2_d = v1_q;
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          o2_q <= '0;
          v2_q <= 1'b0;
        end else begin
          o2_q <= o2_d;
          v2_q <= v2_d;
        end
      end

      assign o  = o2_q;
      assign ov = v2_q;
    end else begin : g_lat1
      assign o  = merged;
      assign ov = v1_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_sram_1r1w_bwe.sv
// +------------------------------------------------------------------+
// | tb_sram_1r1w_bwe : directed bench, three configurations of the RAM |
// | rev 1.0                                                           |
// +------------------------------------------------------------------+
`default_nettype none

module tb_sram_1r1w_bwe;

  logic        clk = 1'b0;
  logic        rst, wr, rd;
  logic [7:0]  wsel;
  logic [8:0]  wadr, radr;
  logic [63:0] i;
  logic [63:0] o_a, o_b, o_c;
  logic        ov_a, ov_b, ov_c, busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_fail   = 0;
  int n, nc;

  always #5 clk = ~clk;

  // a: DEP 512 / LAT 1, b: DEP 512 / LAT 2, c: DEP 300 / LAT 1
  sram_1r1w_bwe #(.WID(64), .DEP(512), .LAT(1), .CLR_ON_RST(1)) u_a (
    .clk(clk), .rst(rst), .wr(wr), .wsel(wsel), .wadr(wadr), .i(i),
    .rd(rd), .radr(radr), .o(o_a), .ov(ov_a), .busy(busy_a));

  sram_1r1w_bwe #(.WID(64), .DEP(512), .LAT(2), .CLR_ON_RST(1)) u_b (
    .clk(clk), .rst(rst), .wr(wr), .wsel(wsel), .wadr(wadr), .i(i),
    .rd(rd), .radr(radr), .o(o_b), .ov(ov_b), .busy(busy_b));

  sram_1r1w_bwe #(.WID(64), .DEP(300), .LAT(1), .CLR_ON_RST(1)) u_c (
    .clk(clk), .rst(rst), .wr(wr), .wsel(wsel), .wadr(wadr), .i(i),
    .rd(rd), .radr(radr), .o(o_c), .ov(ov_c), .busy(busy_c));

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic count_busy;
    n  = 0;
    nc = 0;
    while (busy_a && n < 2000) begin
      if (busy_c) nc++;
      step;
      n++;
    end
  endtask

  task automatic write(input logic [8:0] a, input logic [7:0] s, input logic [63:0] d);
    wr = 1'b1; wadr = a; wsel = s; i = d;
    step;
    wr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; rd = 1'b0; wsel = '0; wadr = '0; radr = '0; i = '0;
    step; step;
    check("rst_o", o_a, 64'h0);
    check("rst_ov", {63'h0, ov_a}, 64'h0);
    check("rst_busy", {63'h0, busy_a}, 64'h1);
    check("rst_o_lat2", o_b, 64'h0);

    // zero-fill length and contents
    rst = 1'b0;
    count_busy;
    check("busy_cycles_512", n, 512);
    check("busy_cycles_300", nc, 300);
    rd = 1'b1;
    for (int k = 0; k < 512; k++) begin
      radr = 9'(k);
      step;
      check("fill_o", o_a, 64'h0);
      check("fill_ov", {63'h0, ov_a}, 64'h1);
    end
    rd = 1'b0;
    step;
    check("ov_drop", {63'h0, ov_a}, 64'h0);

    // write then read, back-to-back reads
    write(9'd7, 8'hFF, {8{8'hA5}});
    write(9'd8, 8'hFF, {8{8'h3C}});
    rd = 1'b1; radr = 9'd7;
    step;
    radr = 9'd8;
    check("rd7_o", o_a, {8{8'hA5}});
    check("rd7_ov", {63'h0, ov_a}, 64'h1);
    step;
    rd = 1'b0;
    check("rd8_o", o_a, {8{8'h3C}});
    check("rd8_ov", {63'h0, ov_a}, 64'h1);
    step;
    check("hold_o", o_a, {8{8'h3C}});
    check("hold_ov", {63'h0, ov_a}, 64'h0);

    // byte write with same-cycle forwarding
    write(9'd3, 8'hFF, {8{8'h11}});
    wr = 1'b1; wsel = 8'h03; wadr = 9'd3; i = {8{8'h22}};
    rd = 1'b1; radr = 9'd3;
    step;
    wr = 1'b0; rd = 1'b0;
    check("fwd_o", o_a, 64'h1111_1111_1111_2222);
    check("fwd_ov", {63'h0, ov_a}, 64'h1);
    step;
    check("fwd_o_lat2", o_b, 64'h1111_1111_1111_2222);
    check("fwd_ov_lat2", {63'h0, ov_b}, 64'h1);
    rd = 1'b1; radr = 9'd3;
    step;
    rd = 1'b0;
    check("stored_bytes", o_a, 64'h1111_1111_1111_2222);

    // LAT=2 read never sees a later write
    write(9'd5, 8'hFF, {8{8'h55}});
    rd = 1'b1; radr = 9'd5;
    step;
    rd = 1'b0;
    wr = 1'b1; wadr = 9'd5; wsel = 8'hFF; i = {8{8'h66}};
    step;
    wr = 1'b0;
    check("lat2_old_o", o_b, {8{8'h55}});
    check("lat2_old_ov", {63'h0, ov_b}, 64'h1);
    rd = 1'b1; radr = 9'd5;
    step;
    rd = 1'b0;
    check("lat2_gap_ov", {63'h0, ov_b}, 64'h0);
    step;
    check("lat2_new_o", o_b, {8{8'h66}});
    check("lat2_new_ov", {63'h0, ov_b}, 64'h1);

    // out-of-range on DEP=300
    write(9'd298, 8'hFF, {8{8'hAB}});
    write(9'd310, 8'hFF, {8{8'h77}});
    rd = 1'b1; radr = 9'd298;
    step;
    check("c298_o", o_c, {8{8'hAB}});
    radr = 9'd310;
    step;
    check("c310_o", o_c, 64'h0);
    check("c310_ov", {63'h0, ov_c}, 64'h1);
    check("a310_o", o_a, {8{8'h77}});
    radr = 9'd299;
    step;
    rd = 1'b0;
    check("c299_o", o_c, 64'h0);
    check("c299_ov", {63'h0, ov_c}, 64'h1);

    // reset in the middle of the fill
    rst = 1'b1;
    step;
    rst = 1'b0;
    repeat (100) step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    check("midrst_o", o_a, 64'h0);
    check("midrst_ov", {63'h0, ov_a}, 64'h0);
    check("midrst_busy", {63'h0, busy_a}, 64'h1);
    count_busy;
    check("midrst_cycles", n, 512);
    check("midrst_o_after", o_a, 64'h0);
    rd = 1'b1; radr = 9'd8;
    step;
    rd = 1'b0;
    check("midrst_rd8", o_a, 64'h0);
    check("midrst_rd8_ov", {63'h0, ov_a}, 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
